// File: rtl/psg_pkg.sv
// psg_pkg: register map, envelope shape bits, volume table and LFSR constants for psg_multi.
// Latency: none (constants and pure functions).
// Backpressure: not applicable.
package psg_pkg;

   // Envelope shape register bit positions
   localparam int SHAPE_HOLD = 0;
   localparam int SHAPE_ALT  = 1;
   localparam int SHAPE_ATT  = 2;
   localparam int SHAPE_CONT = 3;

   // Noise LFSR: 17 bits, shifts right, new bit16 = bit0 ^ bit3
   localparam logic [16:0] LFSR_SEED  = 17'h00001;
   localparam int          LFSR_TAP_A = 0;
   localparam int          LFSR_TAP_B = 3;

   typedef enum logic [1:0] {
      ENV_ATTACK = 2'd0,
      ENV_DECAY  = 2'd1,
      ENV_HOLD   = 2'd2
   } env_state_t;

   // Register offsets; everything above the tone pairs moves with the channel count
   function automatic logic [5:0] reg_tone_lo(input int i);
      return 6'(2 * i);
   endfunction

   function automatic logic [5:0] reg_tone_hi(input int i);
      return 6'(2 * i + 1);
   endfunction

   function automatic logic [5:0] reg_noise(input int nch);
      return 6'(2 * nch);
   endfunction

   function automatic logic [5:0] reg_tdis(input int nch);
      return 6'(2 * nch + 1);
   endfunction

   function automatic logic [5:0] reg_ndis(input int nch);
      return 6'(2 * nch + 2);
   endfunction

   function automatic logic [5:0] reg_vol(input int nch, input int i);
      return 6'(2 * nch + 3 + i);
   endfunction

   function automatic logic [5:0] reg_env_lo(input int nch);
      return 6'(3 * nch + 3);
   endfunction

   function automatic logic [5:0] reg_env_hi(input int nch);
      return 6'(3 * nch + 4);
   endfunction

   function automatic logic [5:0] reg_shape(input int nch);
      return 6'(3 * nch + 5);
   endfunction

   // Logarithmic 4-bit level to 8-bit amplitude
   function automatic logic [7:0] voltab(input logic [3:0] lvl);
      logic [7:0] amp;
      case (lvl)
         4'd0:    amp = 8'd0;
         4'd1:    amp = 8'd2;
         4'd2:    amp = 8'd3;
         4'd3:    amp = 8'd4;
         4'd4:    amp = 8'd6;
         4'd5:    amp = 8'd8;
         4'd6:    amp = 8'd11;
         4'd7:    amp = 8'd16;
         4'd8:    amp = 8'd23;
         4'd9:    amp = 8'd32;
         4'd10:   amp = 8'd45;
         4'd11:   amp = 8'd64;
         4'd12:   amp = 8'd90;
         4'd13:   amp = 8'd128;
         4'd14:   amp = 8'd180;
         default: amp = 8'd255;
      endcase
      return amp;
   endfunction

endpackage

// File: rtl/psg_envelope.sv
// psg_envelope: envelope period counter, 4-bit level and shape state machine.
// Latency: level changes on the tick edge that wraps the counter; a shape write restarts on its own edge.
// Backpressure: none; advances only on tick.
module psg_envelope
   import psg_pkg::*;
#(
   parameter int ENV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [ENV_W-1:0] period,
   input  logic             shape_wr,
   input  logic [3:0]       shape_in,
   output logic [3:0]       shape,
   output logic [3:0]       level
);

   env_state_t       state;
   logic [ENV_W-1:0] cnt;
   logic             wrap;

   // Period 0 behaves as 1, so it wraps on every tick
   always_comb begin
      wrap = (period == '0) ? 1'b1 : (cnt >= period - ENV_W'(1));
   end

   // Counter, level and ramp direction; a shape write takes priority over a step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ENV_HOLD;
         level <= 4'd0;
         cnt   <= '0;
         shape <= 4'd0;
      end else if (shape_wr) begin
         shape <= shape_in;
         cnt   <= '0;
         if (shape_in[SHAPE_ATT]) begin
            state <= ENV_ATTACK;
            level <= 4'd0;
         end else begin
            state <= ENV_DECAY;
            level <= 4'hF;
         end
      end else if (tick && state != ENV_HOLD) begin
         if (!wrap) begin
            cnt <= cnt + ENV_W'(1);
         end else begin
            cnt <= '0;
            if (state == ENV_ATTACK && level != 4'hF) begin
               level <= level + 4'd1;
            end else if (state == ENV_DECAY && level != 4'h0) begin
               level <= level - 4'd1;
            end else if (!shape[SHAPE_CONT]) begin
               state <= ENV_HOLD;
               level <= 4'd0;
            end else if (shape[SHAPE_HOLD]) begin
               state <= ENV_HOLD;
               level <= (shape[SHAPE_ATT] ^ shape[SHAPE_ALT]) ? 4'hF : 4'h0;
            end else if (shape[SHAPE_ALT]) begin
               // Reverse: the new ramp starts from its own start value
               if (state == ENV_ATTACK) begin
                  state <= ENV_DECAY;
                  level <= 4'hF;
               end else begin
                  state <= ENV_ATTACK;
                  level <= 4'h0;
               end
            end else begin
               level <= (state == ENV_ATTACK) ? 4'h0 : 4'hF;
            end
         end
      end
   end

endmodule

// File: rtl/psg_multi.sv
// psg_multi: parametrised programmable sound generator with synchronous register port and mixed output.
// Latency: register read 1 cycle; ch_out 1 cycle after generator state; mix_out 1 cycle after ch_out.
// Backpressure: none; register accesses always complete, generators advance only on clken ticks.
module psg_multi
   import psg_pkg::*;
#(
   parameter int NCH      = 3,
   parameter int TONE_W   = 12,
   parameter int NOISE_W  = 5,
   parameter int ENV_W    = 16,
   parameter int OUT_W    = 8,
   parameter int PRESCALE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clken,
   input  logic                 cs,
   input  logic                 we,
   input  logic [5:0]           addr,
   input  logic [7:0]           wdata,
   output logic [7:0]           rdata,
   output logic [NCH*OUT_W-1:0] ch_out,
   output logic [OUT_W+2:0]     mix_out
);

   localparam int PS_W  = $clog2(PRESCALE);
   localparam int MIX_W = OUT_W + 3;

   logic [TONE_W-1:0]    tone_per [NCH];
   logic [NOISE_W-1:0]   noise_per;
   logic [NCH-1:0]       tdis;
   logic [NCH-1:0]       ndis;
   logic [4:0]           vol [NCH];
   logic [ENV_W-1:0]     env_per;
   logic [3:0]           shape;
   logic [3:0]           env_level;

   logic [PS_W-1:0]      presc;
   logic                 tick;
   logic [TONE_W-1:0]    tone_cnt [NCH];
   logic [NCH-1:0]       tone_wrap;
   logic [NCH-1:0]       tone;
   logic [NOISE_W-1:0]   noise_cnt;
   logic                 noise_wrap;
   logic [16:0]          lfsr;

   logic                 wr_en;
   logic                 rd_en;
   logic                 shape_wr;
   logic [7:0]           rd_val;
   logic [3:0]           ch_lvl [NCH];
   logic [NCH-1:0]       gate;
   logic [NCH*OUT_W-1:0] ch_nxt;
   logic [MIX_W-1:0]     mix_nxt;

   // Access decode and generator tick
   always_comb begin
      wr_en    = cs & we;
      rd_en    = cs & ~we;
      shape_wr = wr_en && (addr == reg_shape(NCH));
      tick     = clken && (presc == PS_W'(PRESCALE - 1));
   end

   // Register file writes; bits beyond each field's width are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            tone_per[i] <= '0;
            vol[i]      <= '0;
         end
         noise_per <= '0;
         tdis      <= '1;
         ndis      <= '1;
         env_per   <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NCH; i++) begin
            if (addr == reg_tone_lo(i)) tone_per[i][7:0]        <= wdata;
            if (addr == reg_tone_hi(i)) tone_per[i][TONE_W-1:8] <= wdata[TONE_W-9:0];
            if (addr == reg_vol(NCH, i)) vol[i]                 <= wdata[4:0];
         end
         if (addr == reg_noise(NCH))  noise_per           <= wdata[NOISE_W-1:0];
         if (addr == reg_tdis(NCH))   tdis                <= wdata[NCH-1:0];
         if (addr == reg_ndis(NCH))   ndis                <= wdata[NCH-1:0];
         if (addr == reg_env_lo(NCH)) env_per[7:0]        <= wdata;
         if (addr == reg_env_hi(NCH)) env_per[ENV_W-1:8]  <= wdata[ENV_W-9:0];
      end
   end

   // Read mux; unmapped addresses and unused bits return 0
   always_comb begin
      rd_val = 8'd0;
      for (int i = 0; i < NCH; i++) begin
         if (addr == reg_tone_lo(i))  rd_val = tone_per[i][7:0];
         if (addr == reg_tone_hi(i))  rd_val = 8'(tone_per[i][TONE_W-1:8]);
         if (addr == reg_vol(NCH, i)) rd_val = {3'd0, vol[i]};
      end
      if (addr == reg_noise(NCH))  rd_val = 8'(noise_per);
      if (addr == reg_tdis(NCH))   rd_val = 8'(tdis);
      if (addr == reg_ndis(NCH))   rd_val = 8'(ndis);
      if (addr == reg_env_lo(NCH)) rd_val = env_per[7:0];
      if (addr == reg_env_hi(NCH)) rd_val = 8'(env_per[ENV_W-1:8]);
      if (addr == reg_shape(NCH))  rd_val = {4'd0, shape};
   end

   // Registered read data, held between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rdata <= 8'd0;
      else if (rd_en) rdata <= rd_val;
   end

   // Prescaler counts clken pulses; power-of-two size wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     presc <= '0;
      else if (clken) presc <= presc + PS_W'(1);
   end

   // Wrap when count reaches max(period,1)-1; a lowered period wraps at once
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         tone_wrap[i] = (tone_per[i] == '0) ? 1'b1 : (tone_cnt[i] >= tone_per[i] - TONE_W'(1));
      end
      noise_wrap = (noise_per == '0) ? 1'b1 : (noise_cnt >= noise_per - NOISE_W'(1));
   end

   // Tone square-wave generators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) tone_cnt[i] <= '0;
         tone <= '0;
      end else if (tick) begin
         for (int i = 0; i < NCH; i++) begin
            if (tone_wrap[i]) begin
               tone_cnt[i] <= '0;
               tone[i]     <= ~tone[i];
            end else begin
               tone_cnt[i] <= tone_cnt[i] + TONE_W'(1);
            end
         end
      end
   end

   // Noise period counter and LFSR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         noise_cnt <= '0;
         lfsr      <= LFSR_SEED;
      end else if (tick) begin
         if (noise_wrap) begin
            noise_cnt <= '0;
            lfsr      <= {lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B], lfsr[16:1]};
         end else begin
            noise_cnt <= noise_cnt + NOISE_W'(1);
         end
      end
   end

   psg_envelope #(
      .ENV_W (ENV_W)
   ) u_env (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .period   (env_per),
      .shape_wr (shape_wr),
      .shape_in (wdata[3:0]),
      .shape    (shape),
      .level    (env_level)
   );

   // Per-channel gating, level select and amplitude lookup
   always_comb begin
      ch_nxt = '0;
      for (int i = 0; i < NCH; i++) begin
         gate[i]   = (tone[i] | tdis[i]) & (lfsr[0] | ndis[i]);
         ch_lvl[i] = vol[i][4] ? env_level : vol[i][3:0];
         ch_nxt[i*OUT_W +: OUT_W] = gate[i] ? (OUT_W'(voltab(ch_lvl[i])) << (OUT_W - 8)) : '0;
      end
   end

   // Sum of registered channel outputs; three extra bits cover eight channels
   always_comb begin
      mix_nxt = '0;
      for (int i = 0; i < NCH; i++) begin
         mix_nxt = mix_nxt + MIX_W'(ch_out[i*OUT_W +: OUT_W]);
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_out  <= '0;
         mix_out <= '0;
      end else begin
         ch_out  <= ch_nxt;
         mix_out <= mix_nxt;
      end
   end

endmodule

// File: doc/psg_multi.md
Name: psg_multi

Overview:
- Parametrised programmable sound generator; successor to the fixed 3-channel 8910-class PSG.
- Configurable channel count, tone/envelope/noise widths and output width.
- Uses a fully synchronous register port, implements all 16 envelope shapes correctly (hold/alternate), and adds a registered mixed output.
- Sits on the sound bus between the CPU I/O decoder and the audio mixer.

Parameters:
- NCH, 3: number of tone channels, 1..8.
- TONE_W, 12: tone period width, 9..16.
- NOISE_W, 5: noise period width, 1..8.
- ENV_W, 16: envelope period width, 9..16.
- OUT_W, 8: per-channel amplitude width, 8..12.
- PRESCALE, 8: clken pulses per generator tick, power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clken  in  1  generator clock enable; register port ignores it.
- cs  in  1  register access select.
- we  in  1  1 = write, 0 = read (qualified by cs).
- addr  in  6  register index.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- ch_out  out  NCH*OUT_W  per-channel amplitude; channel i at [i*OUT_W +: OUT_W].
- mix_out  out  OUT_W+3  unsigned sum of all channels.

Behaviour:
- Reset (async, rst_n low): tone/noise/env periods 0, tone and noise disable masks all 1, volumes 0, shape 0, envelope level 0 and holding, LFSR 17'h00001, prescaler and all counters 0, rdata/ch_out/mix_out 0.
- Register map, N = NCH:
  - 2i / 2i+1: tone i period [7:0] / [TONE_W-1:8].
  - 2N: noise period.
  - 2N+1: tone disable mask [N-1:0].
  - 2N+2: noise disable mask.
  - 2N+3+i: volume i; bit4 = use envelope, [3:0] = fixed level.
  - 3N+3 / 3N+4: env period low / high.
  - 3N+5: shape.
  - Unused write bits are ignored and read back as 0. Unmapped addresses: writes are dropped, reads return 0.
- Write: cs&we at edge k; the register holds the new value after edge k. Read: cs&~we at edge k; rdata is valid after edge k (1-cycle latency). rdata holds its value when there is no read.
- Tick: prescaler counts clken pulses. tick = clken & (prescaler == PRESCALE-1). With clken low, all generator state freezes.
- Tone i, on tick: if cnt ≥ max(period,1)-1 then cnt←0 and toggle tone_i, else cnt+1. Period 0 behaves as 1. A period lowered below cnt wraps on the next tick.
- Noise: a counter counts ticks with the same wrap rule. On wrap, LFSR shifts right, new bit16 = bit0^bit3. noise = bit0.
- Envelope (psg_envelope):
  - Counter counts ticks with the same wrap rule; on wrap, one step of the 4-bit level.
  - Shape bits: 3 CONT, 2 ATT, 1 ALT, 0 HOLD. Attack ramps 0→15; decay ramps 15→0.
  - At the end of each 16-step ramp:
    - CONT=0: hold level 0.
    - CONT=1, HOLD=1: hold at 15 if ATT^ALT, else 0.
    - CONT=1, HOLD=0, ALT=1: reverse direction.
    - Otherwise: restart the same ramp.
  - A shape write restarts the envelope from step 0 (counter 0, level 15 if decay, else 0). If a shape write and an envelope step occur on the same edge, the restart wins.
- Gate: gate_i = (tone_i | tdis_i) & (noise | ndis_i). Level = vol[4] ? env_level : vol[3:0].
- Amplitude: ch_out_i = gate_i ? VOLTAB[level] << (OUT_W-8) : 0, registered every clk (1-cycle latency from state).
  - VOLTAB for 0..15: 0,2,3,4,6,8,11,16,23,32,45,64,90,128,180,255.
- mix_out: registered sum of all ch_out, updated the cycle after ch_out; the width never overflows.
- Reset mid-operation clears everything immediately. Operation resumes on the first clk after rst_n rises.

Decomposition:
- Package psg_pkg holds:
  - register offset functions of NCH;
  - shape bit index constants;
  - VOLTAB function;
  - LFSR seed/taps.
- One sub-module, psg_envelope: counter, level and shape state machine (states ATTACK, DECAY, HOLD).

Test Plan:
- Reset, then read all 3N+6 addresses and two unmapped ones → reset values listed above; unmapped addresses and masks read 0 / 0x07 (N=3).
- Write addr1=0x3F (TONE_W=12), read back → 0x0F. Write addr 0x3E, read → 0.
- clken=1, tone0 period 2, vol0=0x0F, tdis=0x06, ndis=0x07 → ch_out[0] toggles 0↔255 every 16 clk; ch_out[1], ch_out[2] stay 0.
- tdis=ndis=0x07, vols 15/15/15 → mix_out=765 two cycles after the last write. Set vol1=7 → mix_out=526.
- Env period 1, vol0=0x10, shape 0xE → level 0..15 then 15..0, repeating, 8 clk per step. Shape 0x9 → 15..0 then hold 0. Shape 0xB → 15..0 then hold 15.
- Shape write on the same edge as an envelope step → level restarts at step 0. Assert rst_n low mid-ramp → all outputs are 0 in the same cycle.
